heading_pid: RTL

Closed-loop heading controller for the Knight's Tour robot. It consumes the 12-bit `heading` and its `rdy` strobe from the inertial interface, compares them against the desired heading from the command processor, and computes a saturated PID correction. It produces signed left and right wheel speed commands for the PWM/motor-drive stage, so it sits between the inertial interface and the motor drive.

---
 rtl/heading_pid_pkg.sv | 30 +++
 rtl/pid_dterm.sv | 55 +++++
 rtl/heading_pid.sv | 102 ++++++++++
 3 files changed

// File: rtl/heading_pid_pkg.sv
// rtl/heading_pid_pkg.sv - shared widths, default gains and saturation helper for heading_pid
package heading_pid_pkg;

    localparam int HDG_W   = 12;
    localparam int FRWRD_W = 10;
    localparam int ERR_W   = 10;
    localparam int DDIFF_W = 7;
    localparam int INTG_W  = 16;
    localparam int TERM_W  = 14;
    localparam int SPD_W   = 11;

    localparam logic signed [3:0] P_COEFF_DEF = 4'sh3;
    localparam logic signed [5:0] D_COEFF_DEF = 6'sh0E;

    // Clamp a 16-bit signed value into the signed range of a w-bit number.
    // The result is still 16 bits wide; callers size-cast it down to w bits.
    function automatic logic signed [15:0] sat_s(input logic signed [15:0] v, input int w);
        logic signed [15:0] hi;
        logic signed [15:0] lo;
        hi = 16'sh7FFF >>> (16 - w);
        lo = ~hi;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/pid_dterm.sv
// rtl/pid_dterm.sv - error history queue, saturated error difference and derivative gain
module pid_dterm
    import heading_pid_pkg::*;
#(
    parameter logic signed [5:0] D_COEFF = D_COEFF_DEF,
    parameter int                DEPTH   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              err_vld,
    input  logic [ERR_W-1:0]  err_sat,
    output logic [TERM_W-1:0] d_term
);

    logic [ERR_W-1:0]   hist_q [DEPTH];
    logic [ERR_W-1:0]   hist_d [DEPTH];
    logic [ERR_W-1:0]   oldest;
    logic [15:0]        diff;
    logic [DDIFF_W-1:0] d_diff;

    // Shift the current error in on every sample strobe; slot DEPTH-1 is the oldest.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            hist_d[i] = hist_q[i];
        end
        if (err_vld) begin
            hist_d[0] = err_sat;
            for (int i = 1; i < DEPTH; i++) begin
                hist_d[i] = hist_q[i-1];
            end
        end
    end

    // History registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                hist_q[i] <= hist_d[i];
            end
        end
    end

    // Difference against the oldest sample, clamped to 7 bits, then scaled by the gain.
    always_comb begin
        oldest = hist_q[DEPTH-1];
        diff   = {{6{err_sat[ERR_W-1]}}, err_sat} - {{6{oldest[ERR_W-1]}}, oldest};
        d_diff = DDIFF_W'(sat_s(diff, DDIFF_W));
        d_term = {{(TERM_W-DDIFF_W){d_diff[DDIFF_W-1]}}, d_diff} * {{(TERM_W-6){D_COEFF[5]}}, D_COEFF};
    end

endmodule

// File: rtl/heading_pid.sv
// rtl/heading_pid.sv - saturated PID heading loop driving left/right wheel speeds; D path under HEADING_PID_DTERM_EN
module heading_pid
    import heading_pid_pkg::*;
#(
    parameter logic signed [3:0] P_COEFF       = P_COEFF_DEF,
    parameter logic signed [5:0] D_COEFF       = D_COEFF_DEF,
    parameter int                D_QUEUE_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      moving,
    input  logic                      err_vld,
    input  logic signed [HDG_W-1:0]   dsrd_hdg,
    input  logic signed [HDG_W-1:0]   actl_hdg,
    input  logic        [FRWRD_W-1:0] frwrd,
    output logic signed [SPD_W-1:0]   lft_spd,
    output logic signed [SPD_W-1:0]   rght_spd
);

    logic        [HDG_W-1:0]  err;
    logic        [ERR_W-1:0]  err_sat_d, err_sat_q;
    logic        [INTG_W-1:0] intg_d, intg_q;
    logic        [INTG_W-1:0] intg_sum;
    logic                     intg_ovf;
    logic        [TERM_W-1:0] p_term, i_term, d_term;
    logic signed [TERM_W-1:0] pid;
    logic        [SPD_W-1:0]  corr;
    logic        [SPD_W:0]    lft_sum, rght_sum;
    logic        [SPD_W-1:0]  lft_spd_d, lft_spd_q;
    logic        [SPD_W-1:0]  rght_spd_d, rght_spd_q;

    // Heading error wraps in 12 bits (heading is circular), then clamps to 10 bits.
    always_comb begin
        err       = actl_hdg - dsrd_hdg;
        err_sat_d = ERR_W'(sat_s({{4{err[HDG_W-1]}}, err}, ERR_W));
    end

    // Integrator: clear when stopped, otherwise accumulate on a sample unless the add overflows.
    always_comb begin
        intg_sum = intg_q + {{(INTG_W-ERR_W){err_sat_q[ERR_W-1]}}, err_sat_q};
        intg_ovf = (intg_q[INTG_W-1] == err_sat_q[ERR_W-1]) &&
                   (intg_sum[INTG_W-1] != intg_q[INTG_W-1]);
        intg_d   = intg_q;
        if (!moving) begin
            intg_d = '0;
        end else if (err_vld && !intg_ovf) begin
            intg_d = intg_sum;
        end
    end

`ifdef HEADING_PID_DTERM_EN
    pid_dterm #(
        .D_COEFF (D_COEFF),
        .DEPTH   (D_QUEUE_DEPTH)
    ) u_dterm (
        .clk     (clk),
        .rst_n   (rst_n),
        .err_vld (err_vld),
        .err_sat (err_sat_q),
        .d_term  (d_term)
    );
`else
    // No derivative path; the tie-off still references the D parameters so both builds share one parameter list.
    localparam int D_TIE = D_QUEUE_DEPTH * 0 + int'(D_COEFF) * 0;
    assign d_term = TERM_W'(D_TIE);
`endif

    // Sum the terms, drop 3 fraction bits, and steer the correction differentially onto the wheels.
    always_comb begin
        p_term     = {{(TERM_W-ERR_W){err_sat_q[ERR_W-1]}}, err_sat_q} * {{(TERM_W-4){P_COEFF[3]}}, P_COEFF};
        i_term     = {{4{intg_q[INTG_W-1]}}, intg_q[INTG_W-1:6]};
        pid        = p_term + i_term + d_term;
        corr       = SPD_W'(pid >>> 3);
        lft_sum    = {2'b00, frwrd} + {corr[SPD_W-1], corr};
        rght_sum   = {2'b00, frwrd} - {corr[SPD_W-1], corr};
        lft_spd_d  = '0;
        rght_spd_d = '0;
        if (moving) begin
            lft_spd_d  = SPD_W'(sat_s({{4{lft_sum[SPD_W]}}, lft_sum}, SPD_W));
            rght_spd_d = SPD_W'(sat_s({{4{rght_sum[SPD_W]}}, rght_sum}, SPD_W));
        end
    end

    // Pipeline and state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_sat_q  <= '0;
            intg_q     <= '0;
            lft_spd_q  <= '0;
            rght_spd_q <= '0;
        end else begin
            err_sat_q  <= err_sat_d;
            intg_q     <= intg_d;
            lft_spd_q  <= lft_spd_d;
            rght_spd_q <= rght_spd_d;
        end
    end

    assign lft_spd  = lft_spd_q;
    assign rght_spd = rght_spd_q;

endmodule
